hps_spi_bridge: RTL and testbench

HPS_SPI_BRIDGE -- requirements
Module: hps_spi_bridge

---
 rtl/hps_spi_bridge_pkg.sv | 15 +
 rtl/hps_spi_rx_fifo.sv | 52 +++++
 rtl/hps_spi_bridge.sv | 173 +++++++++++++++++
 tb/tb_hps_spi_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_spi_bridge_pkg.sv
// Shared types and helpers for the HPS SPI bridge: transfer state and
// mode-to-edge selection.
package hps_spi_bridge_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/hps_spi_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same cycle.
module hps_spi_rx_fifo #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              rx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              full
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic              pop;
  logic              wr_en;

  assign rx_valid = wr_ptr_q != rd_ptr_q;
  assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign pop      = rx_valid && rx_ready;
  assign wr_en    = push && (!full || pop);
  assign rx_data  = rx_valid ? mem_q[rd_ptr_q[PTR_W-2:0]] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wr_ptr_q[PTR_W-2:0]] <= push_data;
  end

endmodule

// File: rtl/hps_spi_bridge.sv
// SPI slave bridge for the HPS: synchronises the SPI pins and enable lines
// into clk_sys, shifts words in/out, and queues received words in a FIFO.
module hps_spi_bridge
  import hps_spi_bridge_pkg::*;
#(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned N_EN        = 3,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  input  logic [N_EN-1:0]   en_in,
  output logic [N_EN-1:0]   en_out,
  input  logic [WORD_W-1:0] tx_word,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              io_strobe,
  output logic              rx_ovf,
  input  logic              ovf_clr,
  output logic              busy
);
  localparam int unsigned CNT_W       = $clog2(WORD_W);
  localparam logic        SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic [SYNC_STAGES-1:0]           sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]           mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0]           cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0][N_EN-1:0] en_sync_q, en_sync_d;
  logic                             sclk_prev_q, sclk_prev_d;
  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]                rx_sr_q, rx_sr_d;
  logic [WORD_W-1:0]                tx_sr_q, tx_sr_d;
  logic                             skip_q, skip_d;
  logic                             miso_q, miso_d;
  logic                             push_q, push_d;
  logic                             rx_ovf_q, rx_ovf_d;

  logic sclk_s, mosi_s, cs_s;
  logic rise, fall, sample_edge, shift_edge;
  logic fifo_full;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign rise        = sclk_s && !sclk_prev_q;
  assign fall        = !sclk_s && sclk_prev_q;
  assign sample_edge = SAMPLE_RISE ? rise : fall;
  assign shift_edge  = SAMPLE_RISE ? fall : rise;

  assign en_out    = en_sync_q[SYNC_STAGES-1];
  assign spi_miso  = miso_q;
  assign io_strobe = push_q;
  assign rx_ovf    = rx_ovf_q;
  assign busy      = state_q == ACTIVE;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], en_in};
    sclk_prev_d = sclk_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    skip_d      = skip_q;
    miso_d      = miso_q;
    push_d      = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!cs_s) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          tx_sr_d   = tx_word;
          skip_d    = CPHA;
          miso_d    = CPHA ? 1'b0 : tx_word[WORD_W-1];
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[WORD_W-2:0], mosi_s};
            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
              bit_cnt_d = '0;
              push_d    = 1'b1;
              tx_sr_d   = tx_word;
              skip_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // After a reload the next shift edge only presents the new MSB:
          // the CPHA=1 leading edge, or the CPHA=0 trailing edge of the last word.
          if (shift_edge) begin
            if (skip_q) begin
              skip_d = 1'b0;
              miso_d = tx_sr_q[WORD_W-1];
            end else begin
              tx_sr_d = tx_sr_q << 1;
              miso_d  = tx_sr_q[WORD_W-2];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ovf_d = rx_ovf_q;
    if (push_q && fifo_full && !(rx_valid && rx_ready)) rx_ovf_d = 1'b1;
    else if (ovf_clr)                                     rx_ovf_d = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      en_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
      push_q      <= 1'b0;
      rx_ovf_q    <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      en_sync_q   <= en_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      skip_q      <= skip_d;
      miso_q      <= miso_d;
      push_q      <= push_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  hps_spi_rx_fifo #(
    .WORD_W    (WORD_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push     (push_q),
    .push_data(rx_sr_q),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_hps_spi_bridge.sv
// Bench for hps_spi_bridge: one instance per SPI mode sharing cs/mosi, an SPI
// master model, table-driven single-word transfers and hand-written corner cases.
module tb_hps_spi_bridge;

  localparam int HALF = 80;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       spi_clk_r = 4'b1100;
  logic             mosi = 1'b0;
  logic             cs_n = 1'b1;
  logic [2:0]       en_in = 3'b000;
  logic [15:0]      tx_word = 16'h0000;
  logic [3:0]       rx_ready = 4'b0000;
  logic             ovf_clr = 1'b0;

  logic [3:0]       miso_w, rx_valid_w, io_strobe_w, rx_ovf_w, busy_w;
  logic [3:0][15:0] rx_data_w;
  logic [3:0][2:0]  en_out_w;

  int checks = 0;
  int failures = 0;
  int strobe_cnt [4] = '{0, 0, 0, 0};
  logic [15:0] exp_q [$];

  always #5 clk_sys = ~clk_sys;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    hps_spi_bridge #(
      .WORD_W     (16),
      .SYNC_STAGES(2),
      .N_EN       (3),
      .CPOL       (1'((g >> 1) & 1)),
      .CPHA       (1'(g & 1)),
      .FIFO_DEPTH (4)
    ) u_dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .spi_clk  (spi_clk_r[g]),
      .spi_mosi (mosi),
      .spi_cs_n (cs_n),
      .spi_miso (miso_w[g]),
      .en_in    (en_in),
      .en_out   (en_out_w[g]),
      .tx_word  (tx_word),
      .rx_data  (rx_data_w[g]),
      .rx_valid (rx_valid_w[g]),
      .rx_ready (rx_ready[g]),
      .io_strobe(io_strobe_w[g]),
      .rx_ovf   (rx_ovf_w[g]),
      .ovf_clr  (ovf_clr),
      .busy     (busy_w[g])
    );
  end

  always @(posedge clk_sys)
    for (int g = 0; g < 4; g++)
      if (io_strobe_w[g]) strobe_cnt[g] <= strobe_cnt[g] + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    cs_n = 1'b1;
    #(2 * HALF);
  endtask

  // Master: drives mosi MSB first and samples miso on the sample edge.
  task automatic spi_word(input int m, input logic [15:0] dout, input int nbits,
                          output logic [15:0] din);
    din = '0;
    for (int i = 0; i < nbits; i++) begin
      if ((m % 2) == 0) begin
        mosi = dout[15-i];
        #(HALF);
        din = {din[14:0], miso_w[m]};
        spi_clk_r[m] = ~spi_clk_r[m];
        #(HALF);
        spi_clk_r[m] = ~spi_clk_r[m];
      end else begin
        spi_clk_r[m] = ~spi_clk_r[m];
        mosi = dout[15-i];
        #(HALF);
        din = {din[14:0], miso_w[m]};
        spi_clk_r[m] = ~spi_clk_r[m];
        #(HALF);
      end
    end
  endtask

  task automatic drain(input int m);
    int budget;
    while (exp_q.size() > 0) begin
      budget = 0;
      @(negedge clk_sys);
      while (!rx_valid_w[m] && budget < 50) begin
        @(negedge clk_sys);
        budget++;
      end
      if (!rx_valid_w[m]) begin
        check("drain_timeout", 32'(rx_valid_w[m]), 32'd1);
        exp_q.delete();
      end else begin
        check("rx_data", 32'(rx_data_w[m]), 32'(exp_q.pop_front()));
        rx_ready[m] = 1'b1;
        @(negedge clk_sys);
        rx_ready[m] = 1'b0;
      end
    end
    @(negedge clk_sys);
    check("rx_empty", 32'(rx_valid_w[m]), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_miso"},   32'(miso_w[0]),      32'd0);
    check({name, "_valid"},  32'(rx_valid_w[0]),  32'd0);
    check({name, "_data"},   32'(rx_data_w[0]),   32'd0);
    check({name, "_strobe"}, 32'(io_strobe_w[0]), 32'd0);
    check({name, "_ovf"},    32'(rx_ovf_w[0]),    32'd0);
    check({name, "_busy"},   32'(busy_w[0]),      32'd0);
    check({name, "_en"},     32'(en_out_w[0]),    32'd0);
  endtask

  typedef struct {
    int          mode;
    logic [15:0] send;
    logic [15:0] tx;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [15:0] din;
    int          s0;

    vecs[0] = '{0, 16'h1234, 16'hA55A};
    vecs[1] = '{1, 16'hBEEF, 16'hC3C3};
    vecs[2] = '{2, 16'hBEEF, 16'h0F0F};
    vecs[3] = '{3, 16'hBEEF, 16'h8001};
    vecs[4] = '{0, 16'hFFFF, 16'h0000};
    vecs[5] = '{3, 16'h0001, 16'hFFFE};

    repeat (3) @(negedge clk_sys);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    @(posedge clk_sys);
    #3 en_in = 3'b101;
    repeat (3) @(posedge clk_sys);
    #1 check("en_out_sync", 32'(en_out_w[0]), 32'b101);

    for (int v = 0; v < 6; v++) begin
      tx_word = vecs[v].tx;
      s0 = strobe_cnt[vecs[v].mode];
      exp_q.push_back(vecs[v].send);
      cs_begin();
      spi_word(vecs[v].mode, vecs[v].send, 16, din);
      cs_end();
      check("master_rx", 32'(din), 32'(vecs[v].tx));
      check("strobe_one", 32'(strobe_cnt[vecs[v].mode] - s0), 32'd1);
      drain(vecs[v].mode);
    end

    // Six back-to-back words into a depth-4 FIFO with no consumer.
    tx_word = 16'hA55A;
    s0 = strobe_cnt[0];
    cs_begin();
    check("busy_active", 32'(busy_w[0]), 32'd1);
    for (int w = 0; w < 6; w++) begin
      if (exp_q.size() < 4) exp_q.push_back(16'h1001 + 16'(w));
      spi_word(0, 16'h1001 + 16'(w), 16, din);
      check("ovf_master_rx", 32'(din), 32'hA55A);
    end
    cs_end();
    check("busy_idle", 32'(busy_w[0]), 32'd0);
    check("ovf_strobes", 32'(strobe_cnt[0] - s0), 32'd6);
    check("ovf_set", 32'(rx_ovf_w[0]), 32'd1);
    @(negedge clk_sys);
    ovf_clr = 1'b1;
    @(negedge clk_sys);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(rx_ovf_w[0]), 32'd0);
    drain(0);

    // Partial word followed by a full one.
    s0 = strobe_cnt[0];
    cs_begin();
    spi_word(0, 16'hFFFF, 9, din);
    cs_end();
    check("partial_no_strobe", 32'(strobe_cnt[0] - s0), 32'd0);
    check("partial_no_push", 32'(rx_valid_w[0]), 32'd0);
    exp_q.push_back(16'h00FF);
    cs_begin();
    spi_word(0, 16'h00FF, 16, din);
    cs_end();
    check("after_partial_strobe", 32'(strobe_cnt[0] - s0), 32'd1);
    drain(0);

    // Reset mid-transfer with a word already queued.
    cs_begin();
    spi_word(0, 16'h5555, 16, din);
    cs_end();
    @(negedge clk_sys);
    check("pre_reset_valid", 32'(rx_valid_w[0]), 32'd1);
    cs_begin();
    spi_word(0, 16'hF0F0, 5, din);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    cs_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    tx_word = 16'h3C3C;
    exp_q.push_back(16'h8001);
    cs_begin();
    spi_word(0, 16'h8001, 16, din);
    cs_end();
    check("post_reset_master_rx", 32'(din), 32'h3C3C);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
